// File: rtl/fetch_if.sv
// Fetch sequencer bus: run/stall/branch controls in, ROM port and fetch status out.
// The master modport is the sequencer side; the slave modport is the core/ROM side.
interface fetch_if #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned INSTR_W = 10
);
  logic               en;
  logic               stall;
  logic               branch_valid;
  logic [ADDR_W-1:0]  branch_target;
  logic [INSTR_W-1:0] rom_data;
  logic [ADDR_W-1:0]  rom_addr;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid;
  logic               PCload;
  logic               IRload;
  logic [2:0]         state_o;

  modport master (
    input  en, stall, branch_valid, branch_target, rom_data,
    output rom_addr, pc, ir, ir_valid, PCload, IRload, state_o
  );

  modport slave (
    output en, stall, branch_valid, branch_target, rom_data,
    input  rom_addr, pc, ir, ir_valid, PCload, IRload, state_o
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: presents PC to the ROM, waits ROM_WAIT cycles, loads IR,
// then advances the PC or takes a branch redirect.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       INSTR_W  = 10,
  parameter int unsigned       ROM_WAIT = 0,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StAddr  = 3'd1,
    StWait  = 3'd2,
    StLoad  = 3'd3,
    StStall = 3'd4
  } state_e;

  // Counter preload so that WAIT lasts exactly ROM_WAIT cycles.
  localparam logic [3:0] WaitInit = (ROM_WAIT == 0) ? 4'd0 : 4'(ROM_WAIT - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    wait_cnt_d = wait_cnt_q;
    // A redirect overrides whatever the FSM was doing, including a pending IR load.
    if (bus.branch_valid) begin
      pc_d       = bus.branch_target;
      wait_cnt_d = '0;
      state_d    = bus.en ? StAddr : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.en) state_d = StAddr;
        end
        StAddr: begin
          if (ROM_WAIT == 0) begin
            state_d = StLoad;
          end else begin
            wait_cnt_d = WaitInit;
            state_d    = StWait;
          end
        end
        StWait: begin
          if (wait_cnt_q == 4'd0) state_d = StLoad;
          else                    wait_cnt_d = wait_cnt_q - 4'd1;
        end
        StLoad: begin
          ir_d       = bus.rom_data;
          pc_d       = pc_q + ADDR_W'(1);
          ir_valid_d = 1'b1;
          if (bus.stall)   state_d = StStall;
          else if (bus.en) state_d = StAddr;
          else             state_d = StIdle;
        end
        StStall: begin
          if (!bus.stall) state_d = bus.en ? StAddr : StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.pc       = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.state_o  = state_q;
  assign bus.IRload   = (state_q == StLoad) & ~bus.branch_valid;
  assign bus.PCload   = (state_q == StLoad) | bus.branch_valid;

endmodule
